// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer that drives the DDS tuning-word register.
// It loads f_start, then adds f_step n_steps times, holding each tone for dwell cycles.
module dds_sweep_ctrl #(
  parameter int FTW_WIDTH   = 16,
  parameter int DWELL_WIDTH = 16,
  parameter int STEP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rsth,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FTW_WIDTH-1:0]   f_start,
  input  logic [FTW_WIDTH-1:0]   f_step,
  input  logic [STEP_WIDTH-1:0]  n_steps,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [FTW_WIDTH-1:0]   ftw_d,
  output logic                   ftw_enh,
  output logic                   ftw_clrh,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_WIDTH-1:0]  step_idx
);

  // state | meaning
  // IDLE  | waiting for start; ftw_d keeps the last tone
  // LOAD  | first tone strobed into the FTW register
  // DWELL | holding the current tone
  // STEP  | next tone strobed into the FTW register
  // DONE  | one-cycle completion pulse
  // CLR   | one-cycle clear strobe after abort
  typedef enum logic [2:0] {IDLE, LOAD, DWELL, STEP, DONE, CLR} state_t;

  state_t                 state, n_state;
  logic [DWELL_WIDTH-1:0] cnt, n_cnt;
  logic [DWELL_WIDTH-1:0] dwm1_r, n_dwm1;
  logic [FTW_WIDTH-1:0]   step_r, n_step;
  logic [STEP_WIDTH-1:0]  nsteps_r, n_nsteps;
  logic [FTW_WIDTH-1:0]   n_ftw;
  logic [STEP_WIDTH-1:0]  n_idx;
  logic                   n_enh, n_clrh, n_busy, n_done;

  always_ff @(posedge clk) begin
    if (rsth) begin
      state    <= IDLE;
      cnt      <= '0;
      dwm1_r   <= '0;
      step_r   <= '0;
      nsteps_r <= '0;
      ftw_d    <= '0;
      step_idx <= '0;
      ftw_enh  <= 1'b0;
      ftw_clrh <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= n_state;
      cnt      <= n_cnt;
      dwm1_r   <= n_dwm1;
      step_r   <= n_step;
      nsteps_r <= n_nsteps;
      ftw_d    <= n_ftw;
      step_idx <= n_idx;
      ftw_enh  <= n_enh;
      ftw_clrh <= n_clrh;
      busy     <= n_busy;
      done     <= n_done;
    end
  end

  always_comb begin
    n_state  = state;
    n_cnt    = cnt;
    n_dwm1   = dwm1_r;
    n_step   = step_r;
    n_nsteps = nsteps_r;
    n_ftw    = ftw_d;
    n_idx    = step_idx;
    n_enh    = 1'b0;
    n_clrh   = 1'b0;
    n_busy   = 1'b0;
    n_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          // a dwell of 0 behaves as 1, so the reload value never underflows
          n_dwm1   = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
          n_step   = f_step;
          n_nsteps = n_steps;
          n_cnt    = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
          n_ftw    = f_start;
          n_idx    = '0;
          n_enh    = 1'b1;
          n_busy   = 1'b1;
          n_state  = LOAD;
        end
      end
      LOAD, DWELL, STEP: begin
        if (abort) begin
          n_state = CLR;
          n_clrh  = 1'b1;
          n_ftw   = '0;
          n_idx   = '0;
        end else if (cnt == '0) begin
          if (step_idx == nsteps_r) begin
            n_state = DONE;
            n_done  = 1'b1;
          end else begin
            n_state = STEP;
            n_ftw   = ftw_d + step_r;
            n_idx   = step_idx + STEP_WIDTH'(1);
            n_cnt   = dwm1_r;
            n_enh   = 1'b1;
            n_busy  = 1'b1;
          end
        end else begin
          n_state = DWELL;
          n_cnt   = cnt - DWELL_WIDTH'(1);
          n_busy  = 1'b1;
        end
      end
      DONE:    n_state = IDLE;
      CLR:     n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected strobes are queued at stimulus time
// and a negedge monitor pops and compares every enh/clrh/done the design presents.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rsth, start, abort;
  logic [15:0] f_start, f_step, dwell;
  logic [7:0]  n_steps;
  logic [15:0] ftw_d;
  logic        ftw_enh, ftw_clrh, busy, done;
  logic [7:0]  step_idx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          kind;   // 0 enh, 1 clrh, 2 done
    int          at;
    logic [15:0] ftw;
    logic [7:0]  idx;
  } ev_t;
  ev_t q[$];

  dds_sweep_ctrl #(.FTW_WIDTH(16), .DWELL_WIDTH(16), .STEP_WIDTH(8)) dut (
    .clk(clk), .rsth(rsth), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
    .ftw_d(ftw_d), .ftw_enh(ftw_enh), .ftw_clrh(ftw_clrh), .busy(busy),
    .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int kind, int at, logic [15:0] ftw, logic [7:0] idx);
    ev_t e;
    e.kind = kind; e.at = at; e.ftw = ftw; e.idx = idx;
    q.push_back(e);
  endfunction

  task automatic pop_check(input int kind);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_strobe kind=%0d cycle=%0d ftw_d=%h step_idx=%0d required=none",
               kind, cyc, ftw_d, step_idx);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at != cyc || e.ftw != ftw_d || e.idx != step_idx) begin
        fails++;
        $display("FAIL strobe got kind=%0d cycle=%0d ftw_d=%h idx=%0d required kind=%0d cycle=%0d ftw_d=%h idx=%0d",
                 kind, cyc, ftw_d, step_idx, e.kind, e.at, e.ftw, e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ftw_enh)  pop_check(0);
    if (ftw_clrh) pop_check(1);
    if (done)     pop_check(2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ftw_d"}, 32'(ftw_d), 32'h0);
    chk({tag, "_idx"}, 32'(step_idx), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_strobes"}, {29'h0, ftw_enh, ftw_clrh, done}, 32'h0);
  endtask

  // full normal sweep with per-cycle busy/step_idx checks; hold keeps start high one extra cycle
  task automatic run_sweep(input logic [15:0] fs, input logic [15:0] fst, input logic [7:0] n,
                           input logic [15:0] dw, input bit hold);
    int d, b, total;
    d = (dw == 0) ? 1 : int'(dw);
    total = (int'(n) + 1) * d;
    b = cyc;
    for (int k = 0; k <= int'(n); k++) begin
      logic [15:0] w;
      w = fs + 16'(k) * fst;
      push(0, b + 1 + k * d, w, 8'(k));
    end
    push(2, b + 1 + total, fs + 16'(n) * fst, n);
    f_start = fs; f_step = fst; n_steps = n; dwell = dw; start = 1'b1;
    for (int i = 1; i <= total + 2; i++) begin
      tick();
      if (i == 1) begin
        f_start = ~fs; f_step = ~fst; n_steps = ~n; dwell = 16'h7;
        if (!hold) start = 1'b0;
      end
      if (i == 2) start = 1'b0;
      chk("busy", 32'(busy), 32'(i <= total));
      if (i <= total) chk("step_idx", 32'(step_idx), 32'((i - 1) / d));
      else            chk("step_idx_hold", 32'(step_idx), 32'(n));
    end
    chk("queue_drained", 32'(q.size()), 32'h0);
  endtask

  initial begin
    int b;
    rsth = 1'b1; start = 1'b1; abort = 1'b0;
    f_start = 16'h1234; f_step = 16'h0010; n_steps = 8'd2; dwell = 16'd2;
    tick(); chk_zero("reset1");
    tick(); chk_zero("reset2");
    rsth = 1'b0; start = 1'b0;
    tick(); chk_zero("idle");
    tick();

    run_sweep(16'h1000, 16'h0100, 8'd3, 16'd4, 1'b0);
    chk("ftw_hold_idle", 32'(ftw_d), 32'h1300);
    tick();

    run_sweep(16'hFF00, 16'h0100, 8'd1, 16'd1, 1'b0);
    tick();

    // abort mid-sweep
    b = cyc;
    push(0, b + 1, 16'h1000, 8'd0);
    push(0, b + 5, 16'h1100, 8'd1);
    push(1, b + 7, 16'h0000, 8'd0);
    f_start = 16'h1000; f_step = 16'h0100; n_steps = 8'd3; dwell = 16'd4; start = 1'b1;
    tick(); start = 1'b0;
    while (cyc < b + 6) tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ftw", 32'(ftw_d), 32'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_idle_busy", 32'(busy), 32'h0);
    chk("abort_queue", 32'(q.size()), 32'h0);

    // zero dwell, single tone, start held into the busy cycle
    run_sweep(16'h0ABC, 16'h0001, 8'd0, 16'd0, 1'b1);
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("start_abort_idle_busy", 32'(busy), 32'h0);
    chk("start_abort_idle_ftw", 32'(ftw_d), 32'h0ABC);

    // synchronous reset mid-sweep, then a fresh sweep
    b = cyc;
    push(0, b + 1, 16'h1000, 8'd0);
    push(0, b + 5, 16'h1100, 8'd1);
    f_start = 16'h1000; f_step = 16'h0100; n_steps = 8'd3; dwell = 16'd4; start = 1'b1;
    tick(); start = 1'b0;
    while (cyc < b + 8) tick();
    rsth = 1'b1;
    tick(); rsth = 1'b0;
    chk_zero("midreset");
    while (cyc < b + 12) tick();
    run_sweep(16'h2000, 16'h0200, 8'd2, 16'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
